// File: rtl/noc_pkg.sv
// Shared definitions for the 2D-mesh switch.
// Port ids match the XY route computation.
package noc_pkg;

  localparam int RESOURCE = 0;
  localparam int LEFT     = 1;
  localparam int UP       = 2;
  localparam int RIGHT    = 3;
  localparam int DOWN     = 4;

  localparam int IN_N_DEF   = 5;
  localparam int IN_N_W_DEF = 3;

  typedef enum logic [2:0] {
    PORT_RESOURCE = 3'd0,
    PORT_LEFT     = 3'd1,
    PORT_UP       = 3'd2,
    PORT_RIGHT    = 3'd3,
    PORT_DOWN     = 3'd4
  } port_id_e;

endpackage

// File: rtl/out_port_allocator_rr_arbiter.sv
// Combinational round-robin arbiter with request mask.
// Searches upward from ptr_i with wrap-around.
module rr_arbiter
  import noc_pkg::*;
#(
  parameter int N = IN_N_DEF,
  parameter int W = IN_N_W_DEF
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  input  logic [N-1:0] mask_i,
  output logic [N-1:0] win_o,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  localparam logic [W:0] NV = (W+1)'(N);

  logic [N-1:0]   elig;
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [W-1:0]   pos;
  logic           found;
  logic [W:0]     sum;

  assign elig = req_i & ~mask_i;

  // rotate so the pointer slot lands at bit 0
  assign dbl = {elig, elig} >> ptr_i;
  assign rot = dbl[N-1:0];

  always_comb begin
    pos   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        pos   = W'(k);
        found = 1'b1;
      end
    end
  end

  assign sum = {1'b0, ptr_i} + {1'b0, pos};

  always_comb begin
    idx_o = '0;
    win_o = '0;
    vld_o = found;
    if (found) begin
      idx_o = (sum >= NV) ? W'(sum - NV) : W'(sum);
      win_o = N'(1) << idx_o;
    end
  end

endmodule

// File: rtl/out_port_allocator.sv
// Wormhole output-port allocator: round-robin grant
// held per packet until the granted tail flit fires.
module out_port_allocator
  import noc_pkg::*;
#(
  parameter int IN_N   = IN_N_DEF,
  parameter int IN_N_W = IN_N_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IN_N-1:0]   req_i,
  input  logic [IN_N-1:0]   tail_i,
  input  logic              out_rdy_i,
  output logic [IN_N-1:0]   grant_o,
  output logic [IN_N_W-1:0] grant_id_o,
  output logic              busy_o,
  output logic              fire_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  localparam logic [IN_N_W-1:0] LAST =
    IN_N_W'(IN_N - 1);

  logic [0:0]        state_q;
  logic [IN_N-1:0]   grant_q;
  logic [IN_N_W-1:0] gid_q;
  logic [IN_N_W-1:0] ptr_q;

  logic [IN_N_W-1:0] nxt_ptr;
  logic [IN_N_W-1:0] arb_ptr;
  logic [IN_N-1:0]   arb_mask;
  logic [IN_N-1:0]   arb_win;
  logic [IN_N_W-1:0] arb_idx;
  logic              arb_vld;
  logic              locked;
  logic              fire;
  logic              tail_hit;

  assign locked   = (state_q == ST_LOCKED);
  assign fire     = (|(grant_q & req_i)) & out_rdy_i;
  assign tail_hit = fire & (|(grant_q & tail_i));

  assign nxt_ptr = (gid_q == LAST) ? '0
                 : gid_q + 1'b1;

  // one arbiter serves both idle grant and tail handover
  assign arb_ptr  = locked ? nxt_ptr : ptr_q;
  assign arb_mask = locked ? grant_q : '0;

  rr_arbiter #(
    .N (IN_N),
    .W (IN_N_W)
  ) u_arb (
    .req_i  (req_i),
    .ptr_i  (arb_ptr),
    .mask_i (arb_mask),
    .win_o  (arb_win),
    .idx_o  (arb_idx),
    .vld_o  (arb_vld)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_vld) begin
            grant_q <= arb_win;
            gid_q   <= arb_idx;
            state_q <= ST_LOCKED;
          end
        end
        ST_LOCKED: begin
          if (tail_hit) begin
            ptr_q <= nxt_ptr;
            if (arb_vld) begin
              grant_q <= arb_win;
              gid_q   <= arb_idx;
            end else begin
              grant_q <= '0;
              gid_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
          gid_q   <= '0;
        end
      endcase
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = gid_q;
  assign busy_o     = locked;
  assign fire_o     = fire;

endmodule

// File: tb/tb_out_port_allocator.sv
// Directed self-checking bench for out_port_allocator.
// Inputs change at posedge+1, outputs checked at posedge+3.
module tb_out_port_allocator;

  logic       clk;
  logic       rst;
  logic [4:0] req;
  logic [4:0] tail;
  logic       rdy;
  logic [4:0] grant;
  logic [2:0] gid;
  logic       busy;
  logic       fire;

  int checks;
  int errors;

  out_port_allocator #(.IN_N(5), .IN_N_W(3)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_i      (req),
    .tail_i     (tail),
    .out_rdy_i  (rdy),
    .grant_o    (grant),
    .grant_id_o (gid),
    .busy_o     (busy),
    .fire_o     (fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    tail = '0;
    rdy  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    req  = 5'b11111;
    tail = 5'b11111;
    rdy  = 1'b1;
    tick();
    tick();
    settle();
    checks++;
    if (grant !== 5'b0) begin
      errors++;
      $display("FAIL reset_grant got %b want 00000", grant);
    end
    checks++;
    if (gid !== 3'd0) begin
      errors++;
      $display("FAIL reset_gid got %0d want 0", gid);
    end
    checks++;
    if (busy !== 1'b0 || fire !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy_fire got %b%b want 00", busy, fire);
    end
    checks++;
    if (dut.ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL reset_ptr got %0d want 0", dut.ptr_q);
    end
    req  = '0;
    tail = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req  = 5'b00100;
    tail = 5'b00100;
    settle();
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_pre got g=%b b=%b want 00000/0", grant, busy);
    end
    tick();
    settle();
    checks++;
    if (grant !== 5'b00100 || gid !== 3'd2) begin
      errors++;
      $display("FAIL single_grant got %b id %0d want 00100 id 2", grant, gid);
    end
    checks++;
    if (fire !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_fire got f=%b b=%b want 1/1", fire, busy);
    end
    tick();
    req  = '0;
    tail = '0;
    settle();
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0 || gid !== 3'd0) begin
      errors++;
      $display("FAIL single_idle got g=%b b=%b id=%0d want 0/0/0", grant, busy, gid);
    end
    checks++;
    if (dut.ptr_q !== 3'd3) begin
      errors++;
      $display("FAIL single_ptr got %0d want 3", dut.ptr_q);
    end
  endtask

  task automatic test_round_robin();
    int order [6];
    order = '{0, 1, 2, 3, 4, 0};
    do_reset();
    req  = 5'b11111;
    tail = '0;
    settle();
    checks++;
    if (grant !== 5'b0) begin
      errors++;
      $display("FAIL rr_first_idle got %b want 00000", grant);
    end
    tick();
    for (int c = 0; c < 18; c++) begin
      logic [4:0] exp;
      exp  = 5'b00001 << order[c/3];
      tail = (c % 3 == 2) ? exp : 5'b0;
      settle();
      checks++;
      if (grant !== exp || fire !== 1'b1 || busy !== 1'b1
          || gid !== 3'(order[c/3])) begin
        errors++;
        $display("FAIL rr_cycle%0d got g=%b id=%0d f=%b b=%b want g=%b id=%0d f=1 b=1",
                 c, grant, gid, fire, busy, exp, order[c/3]);
      end
      tick();
    end
    req  = '0;
    tail = '0;
  endtask

  task automatic test_bubble();
    do_reset();
    req  = 5'b00010;
    tail = '0;
    tick();
    req = 5'b01010;
    settle();
    checks++;
    if (grant !== 5'b00010 || fire !== 1'b1) begin
      errors++;
      $display("FAIL bubble_head got g=%b f=%b want 00010/1", grant, fire);
    end
    tick();
    for (int c = 0; c < 2; c++) begin
      req = 5'b01000;
      settle();
      checks++;
      if (grant !== 5'b00010 || fire !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bubble_gap%0d got g=%b f=%b b=%b want 00010/0/1",
                 c, grant, fire, busy);
      end
      tick();
    end
    req  = 5'b01010;
    tail = 5'b00010;
    settle();
    checks++;
    if (grant !== 5'b00010 || fire !== 1'b1) begin
      errors++;
      $display("FAIL bubble_tail got g=%b f=%b want 00010/1", grant, fire);
    end
    tick();
    tail = '0;
    settle();
    checks++;
    if (grant !== 5'b01000 || gid !== 3'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bubble_next got g=%b id=%0d b=%b want 01000/3/1", grant, gid, busy);
    end
    req = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req  = 5'b10000;
    tail = '0;
    tick();
    settle();
    checks++;
    if (grant !== 5'b10000 || gid !== 3'd4 || fire !== 1'b1) begin
      errors++;
      $display("FAIL stall_head got g=%b id=%0d f=%b want 10000/4/1", grant, gid, fire);
    end
    tick();
    rdy  = 1'b0;
    tail = 5'b10000;
    for (int c = 0; c < 4; c++) begin
      settle();
      checks++;
      if (grant !== 5'b10000 || fire !== 1'b0 || busy !== 1'b1
          || dut.ptr_q !== 3'd0) begin
        errors++;
        $display("FAIL stall_hold%0d got g=%b f=%b b=%b p=%0d want 10000/0/1/0",
                 c, grant, fire, busy, dut.ptr_q);
      end
      tick();
    end
    rdy = 1'b1;
    settle();
    checks++;
    if (grant !== 5'b10000 || fire !== 1'b1) begin
      errors++;
      $display("FAIL stall_resume got g=%b f=%b want 10000/1", grant, fire);
    end
    tick();
    req  = '0;
    tail = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    req  = 5'b00100;
    tail = 5'b00100;
    tick();
    tick();
    req  = 5'b10000;
    tail = 5'b10000;
    settle();
    checks++;
    if (busy !== 1'b0 || dut.ptr_q !== 3'd3) begin
      errors++;
      $display("FAIL wrap_pre got b=%b p=%0d want 0/3", busy, dut.ptr_q);
    end
    tick();
    settle();
    checks++;
    if (grant !== 5'b10000 || fire !== 1'b1) begin
      errors++;
      $display("FAIL wrap_grant got g=%b f=%b want 10000/1", grant, fire);
    end
    tick();
    settle();
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0 || fire !== 1'b0) begin
      errors++;
      $display("FAIL wrap_masked got g=%b b=%b f=%b want 00000/0/0", grant, busy, fire);
    end
    checks++;
    if (dut.ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL wrap_ptr got %0d want 0", dut.ptr_q);
    end
    tick();
    settle();
    checks++;
    if (grant !== 5'b10000 || gid !== 3'd4 || busy !== 1'b1) begin
      errors++;
      $display("FAIL wrap_regrant got g=%b id=%0d b=%b want 10000/4/1", grant, gid, busy);
    end
    req  = '0;
    tail = '0;
  endtask

  task automatic test_async_reset();
    do_reset();
    req  = 5'b00100;
    tail = 5'b00100;
    tick();
    tick();
    req  = 5'b01000;
    tail = '0;
    tick();
    settle();
    checks++;
    if (grant !== 5'b01000 || fire !== 1'b1 || dut.ptr_q !== 3'd3) begin
      errors++;
      $display("FAIL arst_pre got g=%b f=%b p=%0d want 01000/1/3",
               grant, fire, dut.ptr_q);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (grant !== 5'b0 || busy !== 1'b0 || fire !== 1'b0 || gid !== 3'd0) begin
      errors++;
      $display("FAIL arst_now got g=%b b=%b f=%b id=%0d want 0/0/0/0",
               grant, busy, fire, gid);
    end
    checks++;
    if (dut.ptr_q !== 3'd0) begin
      errors++;
      $display("FAIL arst_ptr got %0d want 0", dut.ptr_q);
    end
    req = 5'b01101;
    tick();
    settle();
    checks++;
    if (grant !== 5'b0) begin
      errors++;
      $display("FAIL arst_hold got g=%b want 00000", grant);
    end
    rst = 1'b0;
    tick();
    settle();
    checks++;
    if (grant !== 5'b00001 || gid !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL arst_restart got g=%b id=%0d b=%b want 00001/0/1", grant, gid, busy);
    end
    req = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    req    = '0;
    tail   = '0;
    rdy    = 1'b1;
    #1;
    test_reset();
    test_single();
    test_round_robin();
    test_bubble();
    test_stall();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/out_port_allocator.md
# out_port_allocator

Per-output-port wormhole allocator for the 2D-mesh switch. One instance sits on each switch output (RESOURCE, LEFT, UP, RIGHT, DOWN). It takes requests from every input buffer whose XY route computation selected this output. It grants the port round-robin to one input and holds the grant for the whole packet, until that input's tail flit transfers. The grant drives the crossbar select for this output.

## Interface
- IN_N, default 5: number of requesting inputs (switch input ports).
- IN_N_W, default 3: width of an input index; must satisfy 2^IN_N_W ≥ IN_N.
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous reset, active-high.
- req_i  input  IN_N  bit i high: input i holds a valid flit routed to this output.
- tail_i  input  IN_N  bit i high: input i's current flit is a tail; a single-flit packet has tail set on its only flit.
- out_rdy_i  input  1  downstream link can accept a flit this cycle.
- grant_o  output  IN_N  one-hot registered grant (all zero when idle).
- grant_id_o  output  IN_N_W  binary index of the granted input; 0 when idle.
- busy_o  output  1  port locked to a packet (state LOCKED).
- fire_o  output  1  combinational: a flit transfers this cycle, i.e. |(grant_o & req_i) & out_rdy_i.

## Operation
- State: FSM with states IDLE and LOCKED, a registered one-hot grant `grant_q`, and a round-robin pointer `ptr_q` (IN_N_W bits, range 0..IN_N-1).
- Arbitration: pick the first requesting input starting at `ptr_q` and searching upward with wrap-around (IN_N-1 → 0).
- IDLE:
  - If any req_i is set, register the winner into `grant_q` and go to LOCKED.
  - Otherwise stay in IDLE with grant zero.
- LOCKED:
  - The grant is held regardless of req_i. A granted input that drops req (bubble) keeps the port; no other input may use it.
  - A transfer requires fire_o.
  - If fire_o is high and tail_i[granted] is high, the packet ends:
    - `ptr_q` ← (granted + 1) mod IN_N.
    - Arbitrate in the same cycle among req_i with the finishing input masked out, using the new pointer.
    - If there is a winner, load its grant and stay in LOCKED (back-to-back, no bubble).
    - Otherwise clear the grant and go to IDLE.
  - A non-tail transfer changes nothing.
- out_rdy_i low: fire_o stays low and state is frozen. Arbitration in IDLE still proceeds, because the grant does not depend on out_rdy_i.
- `ptr_q` changes only at packet end, never at grant time in IDLE.
- req_i bits for inputs ≥ IN_N do not exist. grant_o never has more than one bit set.

## Timing
- Reset values:
  - grant_o = 0, grant_id_o = 0, busy_o = 0, `ptr_q` = 0, state IDLE.
  - fire_o = 0, which follows from grant = 0.
- Reset asserted mid-packet drops the grant immediately (asynchronous). Packet recovery is the upstream's concern.
- Latency:
  - Request in IDLE to grant_o: 1 cycle (registered).
  - First flit can fire in the cycle grant_o is visible.
- Tail transfer in cycle N:
  - The next packet's grant is visible in cycle N+1, or IDLE in N+1 if there is no other requester.
  - busy_o stays high across a back-to-back handover.
- A single-flit packet occupies the port for exactly one fire cycle once granted.
- Simultaneous requests: the winner is purely pointer order. Requests arriving during LOCKED wait; no starvation, since every waiting input is granted within IN_N packets.

## Structure
- Shared package `noc_pkg`:
  - Port ID constants RESOURCE=0, LEFT=1, UP=2, RIGHT=3, DOWN=4, the same mapping the route computation uses.
  - Default IN_N / IN_N_W.
- Sub-module `rr_arbiter`: combinational. Inputs are request vector, pointer and mask; outputs are one-hot winner, binary index and valid. It is reused by future VC allocators.
- Top-level size: FSM, pointer register, grant register and fire logic, about 150–250 lines in total.

## Test plan
- Reset, then req_i=5'b00100 with tail on the first flit and out_rdy_i=1 → grant_o=5'b00100 and grant_id_o=2 one cycle later. fire_o high that cycle, then IDLE next cycle, `ptr_q`=3.
- req_i=5'b11111 from reset, 3-flit packets, out_rdy_i=1 → grant order 0,1,2,3,4,0. Each grant lasts exactly 3 cycles with no idle cycle between packets.
- Granted input 1 drops req for 2 cycles mid-packet while input 3 requests → grant_o stays 5'b00010 and fire_o=0 during the gap. Input 3 is granted only after input 1's tail fires.
- out_rdy_i low for 4 cycles during a packet from input 4 → fire_o=0, grant and `ptr_q` unchanged. Transfer resumes on the first cycle out_rdy_i returns high.
- Tail fires from input 4 while only input 4 requests again next cycle → IDLE for one cycle (input masked), then re-granted to input 4. `ptr_q` wraps to 0.
- rst_i asserted mid-packet, asynchronously between clock edges → grant_o=0, busy_o=0 immediately. After release, `ptr_q`=0 and arbitration restarts from input 0.
